// File: rtl/hazard_ctrl_if.sv
// Decode <-> hazard controller bundle: ID-stage instruction info in, stall/bubble/forward selects out.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  isForw_ON;
  logic                  flush;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  stall;
  logic                  bubble;
  logic [1:0]            forwA;
  logic [1:0]            forwB;
  logic [1:0]            state_o;

  modport master (
    output isForw_ON, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    input  stall, bubble, forwA, forwB, state_o
  );

  modport slave (
    input  isForw_ON, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read,
    output stall, bubble, forwA, forwB, state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / RAW hazard controller with registered forward selects for the EX stage.
// Optional HAZ_STATS_EN adds saturating stall_cycles / forw_events counters.
module hazard_ctrl #(
`ifdef HAZ_STATS_EN
  parameter int STATS_W    = 32,
`endif
  parameter int REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
`ifdef HAZ_STATS_EN
  output logic [STATS_W-1:0] stall_cycles,
  output logic [STATS_W-1:0] forw_events,
`endif
  hazard_ctrl_if.slave       bus
);

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_LU  = 2'd1;
  localparam logic [1:0] ST_RAW = 2'd2;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // WB is not shadowed: the register file is write-through, so WB never stalls or forwards.
  logic                  ex_valid, ex_reg_write, ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid, mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_rd;

  logic [1:0] state, state_d;
  logic [1:0] forw_a, forw_b;
  logic [1:0] sel_a, sel_b;
  logic       ex_m1, ex_m2, mem_m1, mem_m2;
  logic       lu_haz, raw_haz, hazard, advance;

  function automatic logic src_match(logic s_valid, logic s_write, logic [REG_ADDR_W-1:0] s_rd,
                                     logic use_rs, logic [REG_ADDR_W-1:0] rs);
    return s_valid && s_write && (s_rd != '0) && use_rs && (rs == s_rd);
  endfunction

  function automatic logic [1:0] fwd_sel(logic fwd_on, logic ex_hit, logic mem_hit);
    if (!fwd_on)      return SEL_RF;
    else if (ex_hit)  return SEL_EX;
    else if (mem_hit) return SEL_MEM;
    else              return SEL_RF;
  endfunction

  assign ex_m1  = bus.id_valid && src_match(ex_valid,  ex_reg_write,  ex_rd,  bus.id_use_rs1, bus.id_rs1);
  assign ex_m2  = bus.id_valid && src_match(ex_valid,  ex_reg_write,  ex_rd,  bus.id_use_rs2, bus.id_rs2);
  assign mem_m1 = bus.id_valid && src_match(mem_valid, mem_reg_write, mem_rd, bus.id_use_rs1, bus.id_rs1);
  assign mem_m2 = bus.id_valid && src_match(mem_valid, mem_reg_write, mem_rd, bus.id_use_rs2, bus.id_rs2);

  // STALL_LU is a one-cycle state by construction; the guard keeps it that way.
  assign lu_haz  = bus.isForw_ON && ex_mem_read && (ex_m1 || ex_m2) && (state != ST_LU);
  assign raw_haz = !bus.isForw_ON && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
  assign hazard  = lu_haz || raw_haz;

  assign bus.stall  = !bus.flush && hazard;
  assign bus.bubble = bus.flush || hazard;
  assign advance    = bus.id_valid && !bus.bubble;

  assign sel_a = fwd_sel(bus.isForw_ON, ex_m1 && !ex_mem_read, mem_m1);
  assign sel_b = fwd_sel(bus.isForw_ON, ex_m2 && !ex_mem_read, mem_m2);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = ST_RUN;
    if (bus.flush)    state_d = ST_RUN;
    else if (lu_haz)  state_d = ST_LU;
    else if (raw_haz) state_d = ST_RAW;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      forw_a        <= SEL_RF;
      forw_b        <= SEL_RF;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_rd        <= '0;
    end else begin
      state         <= state_d;
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_rd        <= ex_rd;
      ex_valid      <= advance;
      ex_reg_write  <= bus.id_reg_write;
      ex_mem_read   <= bus.id_mem_read;
      ex_rd         <= bus.id_rd;
      forw_a        <= advance ? sel_a : SEL_RF;
      forw_b        <= advance ? sel_b : SEL_RF;
    end
  end

  assign bus.forwA   = forw_a;
  assign bus.forwB   = forw_b;
  assign bus.state_o = state;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      forw_events  <= '0;
    end else begin
      if (bus.stall && !(&stall_cycles))
        stall_cycles <= stall_cycles + STATS_W'(1);
      if (advance && ((sel_a != SEL_RF) || (sel_b != SEL_RF)) && !(&forw_events))
        forw_events <= forw_events + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: in-flight producer model compared every cycle,
// plus directed scenarios with literal expectations. Build with HAZ_STATS_EN to cover the counters.
module tb_hazard_ctrl;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(RW)) bus ();

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cycles, forw_events;
`endif

  hazard_ctrl #(.REG_ADDR_W(RW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef HAZ_STATS_EN
    .stall_cycles(stall_cycles),
    .forw_events(forw_events),
`endif
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          v;
    logic          wr;
    logic          ld;
    logic [RW-1:0] rd;
  } ins_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       adv;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] nstate;
    logic       fwd_evt;
  } exp_t;

  ins_t        hist[$];   // instructions that entered EX, newest last
  logic [1:0]  m_forwA, m_forwB, m_state;
  int unsigned m_stalls, m_fevents;
  bit          ready = 1'b0;
  exp_t        cmp_e, mdl_e;

  function automatic ins_t stage_at(int k);
    ins_t none;
    none = '0;
    if (hist.size() > k) return hist[hist.size() - 1 - k];
    return none;
  endfunction

  // Youngest in-flight writer of rs: 0 = EX, 1 = MEM, -1 = none.
  function automatic int producer(logic [RW-1:0] rs, logic use_rs);
    ins_t e;
    if (!bus.id_valid || !use_rs || rs == '0) return -1;
    for (int k = 0; k < 2; k++) begin
      e = stage_at(k);
      if (e.v && e.wr && e.rd == rs) return k;
    end
    return -1;
  endfunction

  function automatic logic [1:0] sel_of(int p);
    if (!bus.isForw_ON) return 2'b00;
    if (p == 0) return 2'b01;
    if (p == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t expect_now();
    exp_t x;
    ins_t ex;
    int   pa, pb;
    logic lu, raw;
    ex  = stage_at(0);
    pa  = producer(bus.id_rs1, bus.id_use_rs1);
    pb  = producer(bus.id_rs2, bus.id_use_rs2);
    lu  = bus.isForw_ON && ex.ld && (pa == 0 || pb == 0);
    raw = !bus.isForw_ON && (pa >= 0 || pb >= 0);
    x.stall   = !bus.flush && (lu || raw);
    x.bubble  = bus.flush || lu || raw;
    x.adv     = bus.id_valid && !x.bubble;
    x.sa      = sel_of(pa);
    x.sb      = sel_of(pb);
    x.nstate  = bus.flush ? 2'd0 : lu ? 2'd1 : raw ? 2'd2 : 2'd0;
    x.fwd_evt = x.adv && (x.sa != 2'b00 || x.sb != 2'b00);
    return x;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      m_forwA   <= 2'b00;
      m_forwB   <= 2'b00;
      m_state   <= 2'd0;
      m_stalls  <= 0;
      m_fevents <= 0;
      ready     <= 1'b1;
    end else begin
      mdl_e = expect_now();
      if (mdl_e.adv) hist.push_back('{v: 1'b1, wr: bus.id_reg_write, ld: bus.id_mem_read, rd: bus.id_rd});
      else           hist.push_back('0);
      if (hist.size() > 2) void'(hist.pop_front());
      m_forwA <= mdl_e.adv ? mdl_e.sa : 2'b00;
      m_forwB <= mdl_e.adv ? mdl_e.sb : 2'b00;
      m_state <= mdl_e.nstate;
      if (mdl_e.stall)   m_stalls  <= m_stalls + 1;
      if (mdl_e.fwd_evt) m_fevents <= m_fevents + 1;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (ready) begin
      cmp_e = expect_now();
      check("stall",  bus.stall,   cmp_e.stall);
      check("bubble", bus.bubble,  cmp_e.bubble);
      check("forwA",  bus.forwA,   m_forwA);
      check("forwB",  bus.forwB,   m_forwB);
      check("state",  bus.state_o, m_state);
`ifdef HAZ_STATS_EN
      check("stall_cycles", stall_cycles, m_stalls);
      check("forw_events",  forw_events,  m_fevents);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(logic v, logic [RW-1:0] rs1, logic [RW-1:0] rs2, logic u1, logic u2,
                       logic [RW-1:0] rd, logic wr, logic ld);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = wr;
    bus.id_mem_read  = ld;
  endtask

  task automatic nop();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.isForw_ON = 1'b1;
    bus.flush     = 1'b0;
    nop();
    step();
    step();
    check("rst_state", bus.state_o, 2'd0);
    check("rst_forwA", bus.forwA, 2'b00);
    check("rst_forwB", bus.forwB, 2'b00);
    check("rst_stall", bus.stall, 1'b0);
    rst = 1'b0;

    // 1: add x5 in EX, ID add x6,x5,x7 -> forward from EX on A only
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); step();
    drive(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0); settle();
    check("t1_stall", bus.stall, 1'b0);
    step();
    check("t1_forwA", bus.forwA, 2'b01);
    check("t1_forwB", bus.forwB, 2'b00);
    drain();

    // 2: lw x5 in EX, ID add x6,x5,x5 -> one load-use bubble, then MEM forward
    drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); step();
    drive(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); settle();
    check("t2_stall",  bus.stall,  1'b1);
    check("t2_bubble", bus.bubble, 1'b1);
    step();
    check("t2_state_lu", bus.state_o, 2'd1);
    check("t2_stall_rel", bus.stall, 1'b0);
    step();
    check("t2_state_run", bus.state_o, 2'd0);
    check("t2_forwA", bus.forwA, 2'b10);
    check("t2_forwB", bus.forwB, 2'b10);
    drain();

    // 3: forwarding off -> two RAW stall cycles, then advance with 00
    bus.isForw_ON = 1'b0;
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); step();
    drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0); settle();
    check("t3_stall_c0", bus.stall, 1'b1);
    step();
    check("t3_stall_c1", bus.stall, 1'b1);
    check("t3_state_raw", bus.state_o, 2'd2);
    step();
    check("t3_stall_c2", bus.stall, 1'b0);
    step();
    check("t3_state_run", bus.state_o, 2'd0);
    check("t3_forwA", bus.forwA, 2'b00);
    drain();
    bus.isForw_ON = 1'b1;

    // 4: writer to x0 never matches
    drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0); step();
    drive(1, 5'd0, 5'd0, 1, 0, 5'd6, 1, 0); settle();
    check("t4_stall", bus.stall, 1'b0);
    step();
    check("t4_forwA", bus.forwA, 2'b00);
    drain();

    // 5: load-use coinciding with flush -> no stall, bubble, EX invalid
    drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); step();
    drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0);
    bus.flush = 1'b1; settle();
    check("t5_stall",  bus.stall,  1'b0);
    check("t5_bubble", bus.bubble, 1'b1);
    step();
    bus.flush = 1'b0;
    nop(); settle();
    check("t5_state", bus.state_o, 2'd0);
    check("t5_forwA", bus.forwA, 2'b00);
    drain();

    // 6: x5 in MEM (sub) and EX (add), both operands read x5 -> EX wins
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); step();
    drive(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0); step();
    drive(1, 5'd5, 5'd5, 1, 1, 5'd8, 1, 0); settle();
    check("t6_stall", bus.stall, 1'b0);
    step();
    check("t6_forwA", bus.forwA, 2'b01);
    check("t6_forwB", bus.forwB, 2'b01);
`ifdef HAZ_STATS_EN
    // forwarding advances so far: t1, t2, t6; stall cycles: t2 (1) + t3 (2)
    check("t6_forw_events",  forw_events,  32'd3);
    check("t6_stall_cycles", stall_cycles, 32'd3);
`endif
    drain();

    // 7: operands hit different stages -> A from MEM, B from EX
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); step();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0); step();
    drive(1, 5'd5, 5'd7, 1, 1, 5'd9, 1, 0); step();
    check("t7_forwA", bus.forwA, 2'b10);
    check("t7_forwB", bus.forwB, 2'b01);
    drain();

    // 8: forwarding switched on mid STALL_RAW releases the stall
    bus.isForw_ON = 1'b0;
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); step();
    drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0); settle();
    check("t8_stall_c0", bus.stall, 1'b1);
    step();
    check("t8_state_raw", bus.state_o, 2'd2);
    bus.isForw_ON = 1'b1; settle();
    check("t8_stall_rel", bus.stall, 1'b0);
    step();
    check("t8_forwA", bus.forwA, 2'b10);
    check("t8_state_run", bus.state_o, 2'd0);
    drain();

    // 9: reset asserted during a load-use stall
    drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); step();
    drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0); settle();
    check("t9_stall", bus.stall, 1'b1);
    rst = 1'b1;
    step();
    check("t9_state", bus.state_o, 2'd0);
    check("t9_forwA", bus.forwA, 2'b00);
    check("t9_stall_rst", bus.stall, 1'b0);
`ifdef HAZ_STATS_EN
    check("t9_stats_clr", stall_cycles, 32'd0);
`endif
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
